// File: rtl/ccta_sched.sv
// ccta_sched
// ----------
// Two-requester scheduler in front of a single CCTA combine datapath.
// Requesters hand over an operand triple (a, b, c) plus a mode bit over a
// valid/ready handshake; a round-robin arbiter picks one, the operands are
// parked on the dp_* pins for DP_LAT cycles, dp_q is captured and returned
// to the consumer tagged with the owning requester id.
//
// Handshake rule (all three channels): a transfer happens on a rising clock
// edge where valid and ready are both high. The producer holds valid and
// its payload until that edge. The scheduler holds res_valid, res_q and
// res_id until res_ready is seen high.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid/_a/_b/_c/_ctrl   requester N operation (N = 0, 1)
//   reqN_ready                  grant to requester N (IDLE only)
//   dp_a, dp_b, dp_c, dp_ctrl   operands and mode to the shared datapath
//   dp_rst                      active-high datapath reset, low only in EXEC
//   dp_q                        datapath result
//   res_valid, res_q, res_id    result channel to the consumer
//   res_ready                   consumer accepts the result
//   busy                        an operation is in EXEC or RESP
//   op_count                    completed operations, saturating at 255

module ccta_sched #(
   parameter int W      = 4,
   parameter int QW     = 5,
   parameter int DP_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,

   input  logic          req0_valid,
   input  logic [W-1:0]  req0_a,
   input  logic [W-1:0]  req0_b,
   input  logic [W-1:0]  req0_c,
   input  logic          req0_ctrl,
   output logic          req0_ready,

   input  logic          req1_valid,
   input  logic [W-1:0]  req1_a,
   input  logic [W-1:0]  req1_b,
   input  logic [W-1:0]  req1_c,
   input  logic          req1_ctrl,
   output logic          req1_ready,

   output logic [W-1:0]  dp_a,
   output logic [W-1:0]  dp_b,
   output logic [W-1:0]  dp_c,
   output logic          dp_ctrl,
   output logic          dp_rst,
   input  logic [QW-1:0] dp_q,

   output logic          res_valid,
   output logic [QW-1:0] res_q,
   output logic          res_id,
   input  logic          res_ready,

   output logic          busy,
   output logic [7:0]    op_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [3:0] LAT_LOAD = 4'(DP_LAT - 1);

   state_t        state_q, state_d;
   logic          last_q, last_d;
   logic [3:0]    lat_cnt_q, lat_cnt_d;
   logic [W-1:0]  dp_a_q, dp_a_d;
   logic [W-1:0]  dp_b_q, dp_b_d;
   logic [W-1:0]  dp_c_q, dp_c_d;
   logic          dp_ctrl_q, dp_ctrl_d;
   logic [QW-1:0] res_q_q, res_q_d;
   logic          res_id_q, res_id_d;
   logic [7:0]    op_count_q, op_count_d;

   logic          gnt0, gnt1;
   logic          accept;

   // Round-robin: with both requesters valid, the one that did not win
   // last time is granted. A lone valid requester always wins.
   always_comb begin
      gnt1 = req1_valid & (~req0_valid | ~last_q);
      gnt0 = req0_valid & ~gnt1;
   end

   // Grants are combinational and only exist in IDLE; rst_n gates them so
   // nothing can be accepted while reset is asserted.
   always_comb begin
      req0_ready = rst_n & (state_q == ST_IDLE) & gnt0;
      req1_ready = rst_n & (state_q == ST_IDLE) & gnt1;
      accept     = req0_ready | req1_ready;
   end

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      lat_cnt_d  = lat_cnt_q;
      dp_a_d     = dp_a_q;
      dp_b_d     = dp_b_q;
      dp_c_d     = dp_c_q;
      dp_ctrl_d  = dp_ctrl_q;
      res_q_d    = res_q_q;
      res_id_d   = res_id_q;
      op_count_d = op_count_q;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (gnt1) begin
                  dp_a_d    = req1_a;
                  dp_b_d    = req1_b;
                  dp_c_d    = req1_c;
                  dp_ctrl_d = req1_ctrl;
               end else begin
                  dp_a_d    = req0_a;
                  dp_b_d    = req0_b;
                  dp_c_d    = req0_c;
                  dp_ctrl_d = req0_ctrl;
               end
               res_id_d  = gnt1;
               last_d    = gnt1;
               lat_cnt_d = LAT_LOAD;
               state_d   = ST_EXEC;
            end
         end

         // lat_cnt counts down from DP_LAT-1, so EXEC spans DP_LAT cycles
         // and dp_q is captured on the edge ending the last of them.
         ST_EXEC: begin
            if (lat_cnt_q != 4'd0) begin
               lat_cnt_d = lat_cnt_q - 4'd1;
            end else begin
               res_q_d = dp_q;
               state_d = ST_RESP;
            end
         end

         ST_RESP: begin
            if (res_ready) begin
               if (op_count_q != 8'hFF) begin
                  op_count_d = op_count_q + 8'd1;
               end
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         last_q     <= 1'b1;
         lat_cnt_q  <= 4'd0;
         dp_a_q     <= '0;
         dp_b_q     <= '0;
         dp_c_q     <= '0;
         dp_ctrl_q  <= 1'b0;
         res_q_q    <= '0;
         res_id_q   <= 1'b0;
         op_count_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         lat_cnt_q  <= lat_cnt_d;
         dp_a_q     <= dp_a_d;
         dp_b_q     <= dp_b_d;
         dp_c_q     <= dp_c_d;
         dp_ctrl_q  <= dp_ctrl_d;
         res_q_q    <= res_q_d;
         res_id_q   <= res_id_d;
         op_count_q <= op_count_d;
      end
   end

   // Status outputs decode straight from the state register, so an async
   // reset clears res_valid/busy and raises dp_rst without waiting a clock.
   always_comb begin
      dp_a      = dp_a_q;
      dp_b      = dp_b_q;
      dp_c      = dp_c_q;
      dp_ctrl   = dp_ctrl_q;
      dp_rst    = (state_q != ST_EXEC);
      res_valid = (state_q == ST_RESP);
      res_q     = res_q_q;
      res_id    = res_id_q;
      busy      = (state_q != ST_IDLE);
      op_count  = op_count_q;
   end

endmodule

// File: doc/ccta_sched.md
Name: ccta_sched

Overview:
- Two-requester scheduler that shares one CCTA combine datapath: 4-bit operands A/B/C, a ctrl select, and a 5-bit result q.
- Accepts operand triples over valid/ready handshakes and arbitrates round-robin between requesters.
- Drives the shared datapath's operand, ctrl and reset pins, samples q after a fixed latency, and returns the result tagged with the requester id.
- Sits between the client logic and the single CCTA instance.

Parameters:
- W, 4, operand width (A, B, C).
- QW, 5, result width (q).
- DP_LAT, 1, cycles from operands driven to q valid; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req0_valid / req1_valid  in  1  requester 0/1 has an operation.
- req0_a, req0_b, req0_c / req1_a, req1_b, req1_c  in  W  operands.
- req0_ctrl / req1_ctrl  in  1  datapath mode select.
- req0_ready / req1_ready  out  1  grant; accept = valid & ready.
- dp_a, dp_b, dp_c  out  W  operands to the datapath.
- dp_ctrl  out  1  mode to the datapath.
- dp_rst  out  1  active-high datapath reset; high whenever idle.
- dp_q  in  QW  datapath result.
- res_valid  out  1  result available.
- res_q  out  QW  captured result.
- res_id  out  1  id of the requester that owns res_q.
- res_ready  in  1  consumer takes the result.
- busy  out  1  high in EXEC or RESP.
- op_count  out  8  completed operations, saturating at 255.

Behaviour:
- Reset (rst_n low, async): state IDLE; res_valid=0, res_q=0, res_id=0; dp_a/b/c=0, dp_ctrl=0, dp_rst=1; busy=0; op_count=0; rr pointer last=1, so req0 wins first. req*_ready are forced to 0 while rst_n is low.
- Reset mid-operation: the in-flight operation is discarded and no response is produced.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational, high only for the granted requester and only in IDLE.
  - Only one requester is valid: it is granted.
  - Both are valid: the requester not granted last is granted.
  - On accept: latch operands and ctrl into the dp_* registers, record res_id, load lat_cnt=DP_LAT-1, update last=id, go to EXEC.
  - No valid requester: stay in IDLE with dp_rst=1.
- EXEC:
  - dp_rst=0; dp_a/b/c/ctrl hold the latched values; both readies are 0.
  - lat_cnt>0: decrement.
  - lat_cnt==0: register dp_q into res_q, go to RESP.
  - EXEC lasts exactly DP_LAT cycles.
- RESP:
  - res_valid=1; res_q and res_id stable; dp_rst=1; dp_* operands hold.
  - res_ready=1: clear res_valid, increment op_count (saturating at 255), go to IDLE.
  - res_valid is never dropped without res_ready.
- Timing:
  - Accept in cycle t; res_valid rises at the edge ending cycle t+DP_LAT, visible from cycle t+DP_LAT+1.
  - There is no bypass from RESP to accept, so back-to-back operations are spaced DP_LAT+2 cycles apart.
  - res_q is left unchanged when returning to IDLE.
- Arithmetic: the block does no arithmetic on data. op_count saturates at 255 and never wraps.
- Requester inputs may change freely while not granted. Operands are sampled only on the accept edge.

Test Plan:
The bench stub datapath is combinational: q = A+B when ctrl=0, q = A+C when ctrl=1 (5-bit). DP_LAT=1.
1. Reset: hold rst_n=0, then release with both requesters idle -> dp_rst=1, res_valid=0, op_count=0, both readies 0 during reset.
2. Single request: req0 with A=4, B=1, C=9, ctrl=0 -> req0_ready high in the accept cycle; dp_a=4 during EXEC; two cycles later res_valid=1, res_q=5'h05, res_id=0. Pulse res_ready -> op_count=1.
3. Contention: req0 and req1 held valid continuously, req0 = {A=D, B=C, ctrl=0}, req1 = {A=6, B=5, C=A, ctrl=1} -> grants alternate 0,1,0,1; results 5'h19, 5'h10 in that order; 3-cycle spacing.
4. Backpressure: res_ready=0 for 5 cycles in RESP with req1 valid -> res_valid and res_q stay stable, req1_ready stays 0; result taken on res_ready=1, then req1 is accepted.
5. Mid-operation reset: assert rst_n=0 during EXEC -> immediate clear of res_valid and busy, dp_rst=1; no result appears after release.
6. Saturation: complete 260 operations -> op_count reads 255; rerun with DP_LAT=3 -> res_valid appears exactly 4 cycles after accept.
